// File: rtl/pwm_dimmer.sv
// -----------------------------------------------------------------------------
// pwm_dimmer
//
// Multi-channel LED dimmer. A push button steps the brightness level of the
// channel addressed by sel up or down. Each channel is driven as PWM from one
// free-running counter shared by all channels.
//
// Timing structure:
//   prescaler (DIV_BITS) -> tick -> PWM counter cnt (PWM_BITS)
//   One PWM period lasts 2**(DIV_BITS+PWM_BITS) clk cycles.
//
// Level handling:
//   pending[i] : level being edited by button steps (visible on level_o)
//   active[i]  : level driving pwm_out[i]; copied from pending[i] only at the
//                end of a PWM period, so a period is never cut short or
//                stretched by an edit.
//   Levels run 0..2**PWM_BITS; level L gives a duty cycle of L/2**PWM_BITS.
//
// Ports:
//   clk      in   1            system clock, rising edge
//   rst      in   1            asynchronous reset, active low
//   r        in   1            raw button level, asynchronous to clk
//   up       in   1            step direction: 1 = increment, 0 = decrement
//   sel      in   SEL_W        channel addressed by the next step
//   pwm_out  out  CHANNELS     registered PWM outputs, bit i = channel i
//   level_o  out  PWM_BITS+1   pending level of channel sel (0 if sel invalid)
//   tick     out  1            prescaler enable, one cycle every 2**DIV_BITS
//
// Build option:
//   DIMMER_WRAP_EN  undefined: levels saturate at 0 and 2**PWM_BITS
//                   defined:   levels wrap (MAX + 1 -> 0, 0 - 1 -> MAX)
// -----------------------------------------------------------------------------
module pwm_dimmer #(
    parameter int CHANNELS = 3,
    parameter int PWM_BITS = 4,
    parameter int DIV_BITS = 8,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                r,
    input  logic                up,
    input  logic [SEL_W-1:0]    sel,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [PWM_BITS:0]   level_o,
    output logic                tick
);

    localparam int LVL_W = PWM_BITS + 1;
    localparam logic [LVL_W-1:0]    LVL_MAX = LVL_W'(2 ** PWM_BITS);
    localparam logic [LVL_W-1:0]    LVL_ONE = LVL_W'(1);
    localparam logic [DIV_BITS-1:0] DIV_ONE = DIV_BITS'(1);
    localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_BITS-1:0] presc;
    logic [PWM_BITS-1:0] cnt;
    logic                s1;
    logic                s2;
    logic                s3;
    logic [LVL_W-1:0]    pending     [CHANNELS];
    logic [LVL_W-1:0]    active      [CHANNELS];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                step;
    logic                boundary;
    logic [LVL_W-1:0]    pending_nxt [CHANNELS];
    logic [CHANNELS-1:0] pwm_nxt;

    // One level step in the selected direction, with the configured
    // out-of-range behaviour at either end of 0..LVL_MAX.
    function automatic logic [LVL_W-1:0] step_level(
        input logic [LVL_W-1:0] cur,
        input logic             inc
    );
        logic [LVL_W-1:0] res;
`ifdef DIMMER_WRAP_EN
        if (inc) begin
            res = (cur == LVL_MAX) ? '0 : cur + LVL_ONE;
        end else begin
            res = (cur == '0) ? LVL_MAX : cur - LVL_ONE;
        end
`else
        if (inc) begin
            res = (cur == LVL_MAX) ? cur : cur + LVL_ONE;
        end else begin
            res = (cur == '0) ? cur : cur - LVL_ONE;
        end
`endif
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Prescaler and shared PWM counter
    // ------------------------------------------------------------------
    assign tick     = &presc;
    // Last tick of the last count value: the edge that starts a new period.
    assign boundary = tick && (&cnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            cnt   <= '0;
        end else begin
            presc <= presc + DIV_ONE;
            if (tick) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Button synchroniser and rising-edge detector
    // ------------------------------------------------------------------
    // s1/s2 form the two-flop synchroniser; s3 is the previous synchronised
    // value, so step is a single-cycle pulse per press no matter how long
    // the button is held.
    assign step = s2 & ~s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= r;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // ------------------------------------------------------------------
    // Pending level update
    // ------------------------------------------------------------------
    // A sel value with no matching channel matches no loop index, so the
    // step is dropped without any explicit range check.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            pending_nxt[i] = pending[i];
            if (step && (sel == SEL_W'(i))) begin
                pending_nxt[i] = step_level(pending[i], up);
            end
        end
    end

    // ------------------------------------------------------------------
    // Level registers
    // ------------------------------------------------------------------
    // active samples the pending value held before the boundary edge; a
    // step landing on that same edge only reaches pending and is picked up
    // one period later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                pending[i] <= pending_nxt[i];
                if (boundary) begin
                    active[i] <= pending[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // PWM compare and output register
    // ------------------------------------------------------------------
    // cnt is zero-extended so level MAX compares above every count value
    // (constant high) and level 0 compares below all of them (constant low).
    always_comb begin
        pwm_nxt = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            pwm_nxt[i] = ({1'b0, cnt} < active[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= pwm_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Level readback
    // ------------------------------------------------------------------
    always_comb begin
        level_o = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i)) begin
                level_o = pending[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_dimmer.sv
// -----------------------------------------------------------------------------
// tb_pwm_dimmer
//
// Directed bench for pwm_dimmer with CHANNELS=3, PWM_BITS=2, DIV_BITS=2
// (levels 0..4, tick every 4 cycles, PWM period 16 cycles).
// Expected values are queued as stimulus is applied and popped when the
// corresponding DUT output is sampled on the falling clock edge.
// Edge counter ecnt: edges since reset release. cnt after edge n equals
// (n/4)%4, so active levels load at edges that are multiples of 16, and the
// 16 samples after edges E+1..E+16 show one full period of that load.
// -----------------------------------------------------------------------------
module tb_pwm_dimmer;

    localparam int CH   = 3;
    localparam int MAXL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       r   = 1'b0;
    logic       up  = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [2:0] pwm_out;
    logic [2:0] level_o;
    logic       tick;

    pwm_dimmer #(
        .CHANNELS(3),
        .PWM_BITS(2),
        .DIV_BITS(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .r      (r),
        .up     (up),
        .sel    (sel),
        .pwm_out(pwm_out),
        .level_o(level_o),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    int ecnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) ecnt <= 0;
        else      ecnt <= ecnt + 1;
    end

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   lvl[CH];
    int   hi[CH];

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty got=%0d want=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s got=%0d want=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic int model_step(input int cur, input bit inc);
`ifdef DIMMER_WRAP_EN
        if (inc) return (cur == MAXL) ? 0 : cur + 1;
        else     return (cur == 0) ? MAXL : cur - 1;
`else
        if (inc) return (cur == MAXL) ? MAXL : cur + 1;
        else     return (cur == 0) ? 0 : cur - 1;
`endif
    endfunction

    // Called just after a falling edge; leaves r low for two sampled cycles.
    task automatic press(input logic [1:0] s, input bit dir);
        sel = s;
        up  = dir;
        r   = 1'b1;
        repeat (3) @(negedge clk);
        r = 1'b0;
        repeat (2) @(negedge clk);
        if (s < 2'd3) lvl[s] = model_step(lvl[s], dir);
    endtask

    task automatic wait_edge(input int n);
        while (ecnt < n) @(negedge clk);
    endtask

    function automatic int next_boundary(input int margin);
        return ((ecnt + margin) / 16 + 1) * 16;
    endfunction

    task automatic measure(input int e_edge);
        wait_edge(e_edge + 1);
        for (int i = 0; i < CH; i++) hi[i] = 0;
        repeat (16) begin
            for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
            @(negedge clk);
        end
    endtask

    task automatic check_period(input int e_edge, input string tag);
        for (int i = 0; i < CH; i++) push_exp($sformatf("%s_ch%0d", tag, i), 4 * lvl[i]);
        measure(e_edge);
        for (int i = 0; i < CH; i++) check(hi[i]);
    endtask

    initial begin
        int e_b;
        int old1;
        for (int i = 0; i < CH; i++) lvl[i] = 0;

        // ---- 1. reset behaviour --------------------------------------
        repeat (2) @(negedge clk);
        rst = 1'b1;
        press(2'd0, 1'b1);
        push_exp("pre_reset_level", lvl[0]);
        check(32'(level_o));
        while (ecnt % 4 != 3) @(negedge clk);
        push_exp("pre_reset_tick", 1);
        check(32'(tick));
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < CH; i++) lvl[i] = 0;
        push_exp("rst_pwm", 0);
        check(32'(pwm_out));
        push_exp("rst_tick", 0);
        check(32'(tick));
        push_exp("rst_level", 0);
        check(32'(level_o));
        @(negedge clk);
        rst = 1'b1;
        push_exp("tick_c1", 0);
        push_exp("tick_c2", 0);
        push_exp("tick_c3", 1);
        repeat (3) begin
            @(negedge clk);
            check(32'(tick));
        end

        // ---- 2. two up presses on channel 0 -------------------------
        press(2'd0, 1'b1);
        press(2'd0, 1'b1);
        push_exp("ch0_level2", 2);
        check(32'(level_o));
        e_b = next_boundary(0);
        check_period(e_b, "duty_a");
        check_period(e_b + 16, "duty_a2");

        // ---- 3. held button gives one step, at edge k+2 --------------
        sel = 2'd1;
        up  = 1'b1;
        r   = 1'b1;
        push_exp("hold_k", 0);
        push_exp("hold_k1", 0);
        push_exp("hold_k2", 1);
        repeat (3) begin
            @(negedge clk);
            check(32'(level_o));
        end
        repeat (97) @(negedge clk);
        r = 1'b0;
        repeat (3) @(negedge clk);
        lvl[1] = 1;
        push_exp("hold_single", 1);
        check(32'(level_o));

        // ---- 4. five up presses on channel 2 -------------------------
        repeat (5) press(2'd2, 1'b1);
        push_exp("ch2_five_up", lvl[2]);
        check(32'(level_o));
        check_period(next_boundary(0), "duty_b");

        // ---- 5. down at level 0 --------------------------------------
        press(2'd0, 1'b0);
        press(2'd0, 1'b0);
        push_exp("ch0_down_to0", 0);
        check(32'(level_o));
        press(2'd0, 1'b0);
        push_exp("ch0_down_at0", lvl[0]);
        check(32'(level_o));

        // ---- 6. invalid sel, then press on a boundary edge -----------
        press(2'd3, 1'b1);
        push_exp("sel3_level", 0);
        check(32'(level_o));
        for (int i = 0; i < CH; i++) begin
            sel = 2'(i);
            #1;
            push_exp($sformatf("keep_ch%0d", i), lvl[i]);
            check(32'(level_o));
            @(negedge clk);
        end
        e_b  = next_boundary(4);
        wait_edge(e_b - 3);
        old1 = lvl[1];
        for (int i = 0; i < CH; i++)
            push_exp($sformatf("coinc_now_ch%0d", i), 4 * ((i == 1) ? old1 : lvl[i]));
        fork
            press(2'd1, 1'b1);
            measure(e_b);
        join
        for (int i = 0; i < CH; i++) check(hi[i]);
        push_exp("coinc_pending", lvl[1]);
        check(32'(level_o));
        check_period(e_b + 16, "coinc_next");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
